// File: rtl/rs_int_station.sv
// Integer reservation station: allocates into the lowest free entry, snoops CDB channels to
// resolve operand tags, and issues the lowest-index ready entry.
module rs_int_station #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CDB_CH     = 2,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ROB_ADDR_W = 4,
    parameter int unsigned OPGEN_W    = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         write_en,
    output logic                         write_ready,
    input  logic [ROB_ADDR_W-1:0]        rob_addr_in,
    input  logic [OPGEN_W-1:0]           opgen_in,
    input  logic                         operand_is_ref_1_in,
    input  logic                         operand_is_ref_2_in,
    input  logic [DATA_W-1:0]            operand_data_1_in,
    input  logic [DATA_W-1:0]            operand_data_2_in,
    input  logic [CDB_CH-1:0]            bus_en,
    input  logic [CDB_CH*ROB_ADDR_W-1:0] bus_ref_id_in,
    input  logic [CDB_CH*DATA_W-1:0]     bus_data_in,
    output logic                         issue_valid,
    input  logic                         issue_ready,
    output logic [ROB_ADDR_W-1:0]        rob_addr_out,
    output logic [OPGEN_W-1:0]           opgen_out,
    output logic [DATA_W-1:0]            operand_data_1_out,
    output logic [DATA_W-1:0]            operand_data_2_out,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {StFree, StWait, StReady} ent_st_e;

    ent_st_e                 st_q  [DEPTH];
    ent_st_e                 st_d  [DEPTH];
    logic [ROB_ADDR_W-1:0]   rob_q [DEPTH];
    logic [ROB_ADDR_W-1:0]   rob_d [DEPTH];
    logic [OPGEN_W-1:0]      opg_q [DEPTH];
    logic [OPGEN_W-1:0]      opg_d [DEPTH];
    logic                    ref1_q[DEPTH];
    logic                    ref1_d[DEPTH];
    logic                    ref2_q[DEPTH];
    logic                    ref2_d[DEPTH];
    logic [DATA_W-1:0]       d1_q  [DEPTH];
    logic [DATA_W-1:0]       d1_d  [DEPTH];
    logic [DATA_W-1:0]       d2_q  [DEPTH];
    logic [DATA_W-1:0]       d2_d  [DEPTH];

    logic [DEPTH-1:0] free_oh;
    logic [DEPTH-1:0] iss_oh;
    logic             write_fire;
    logic             issue_fire;
    logic [DATA_W:0]  in1_res;
    logic [DATA_W:0]  in2_res;
    logic [DATA_W:0]  w1_res  [DEPTH];
    logic [DATA_W:0]  w2_res  [DEPTH];

    // Returns {still_ref, data}; the lowest matching channel wins.
    function automatic logic [DATA_W:0] resolve(
        input logic                         is_ref,
        input logic [DATA_W-1:0]            data,
        input logic [CDB_CH-1:0]            en,
        input logic [CDB_CH*ROB_ADDR_W-1:0] ids,
        input logic [CDB_CH*DATA_W-1:0]     vals
    );
        logic [DATA_W:0] res;
        logic            hit;
        res = {is_ref, data};
        hit = 1'b0;
        if (is_ref) begin
            for (int c = 0; c < CDB_CH; c++) begin
                if (!hit && en[c] &&
                    ids[c*ROB_ADDR_W +: ROB_ADDR_W] == data[ROB_ADDR_W-1:0]) begin
                    hit = 1'b1;
                    res = {1'b0, vals[c*DATA_W +: DATA_W]};
                end
            end
        end
        return res;
    endfunction

    always_comb begin
        free_oh     = '0;
        iss_oh      = '0;
        write_ready = 1'b0;
        issue_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!write_ready && st_q[i] == StFree) begin
                free_oh[i]  = 1'b1;
                write_ready = 1'b1;
            end
            if (!issue_valid && st_q[i] == StReady) begin
                iss_oh[i]   = 1'b1;
                issue_valid = 1'b1;
            end
        end
    end

    assign write_fire = write_en & write_ready;
    assign issue_fire = issue_valid & issue_ready;

    always_comb begin
        in1_res = resolve(operand_is_ref_1_in, operand_data_1_in, bus_en, bus_ref_id_in,
                          bus_data_in);
        in2_res = resolve(operand_is_ref_2_in, operand_data_2_in, bus_en, bus_ref_id_in,
                          bus_data_in);
        for (int i = 0; i < DEPTH; i++) begin
            w1_res[i] = resolve(ref1_q[i], d1_q[i], bus_en, bus_ref_id_in, bus_data_in);
            w2_res[i] = resolve(ref2_q[i], d2_q[i], bus_en, bus_ref_id_in, bus_data_in);
        end
    end

    // Write targets a FREE entry and issue a READY one, so the three paths never collide.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            st_d[i]   = st_q[i];
            rob_d[i]  = rob_q[i];
            opg_d[i]  = opg_q[i];
            ref1_d[i] = ref1_q[i];
            ref2_d[i] = ref2_q[i];
            d1_d[i]   = d1_q[i];
            d2_d[i]   = d2_q[i];
            if (st_q[i] == StWait) begin
                ref1_d[i] = w1_res[i][DATA_W];
                d1_d[i]   = w1_res[i][DATA_W-1:0];
                ref2_d[i] = w2_res[i][DATA_W];
                d2_d[i]   = w2_res[i][DATA_W-1:0];
                st_d[i]   = (w1_res[i][DATA_W] || w2_res[i][DATA_W]) ? StWait : StReady;
            end
            if (issue_fire && iss_oh[i]) begin
                st_d[i] = StFree;
            end
            if (write_fire && free_oh[i]) begin
                rob_d[i]  = rob_addr_in;
                opg_d[i]  = opgen_in;
                ref1_d[i] = in1_res[DATA_W];
                d1_d[i]   = in1_res[DATA_W-1:0];
                ref2_d[i] = in2_res[DATA_W];
                d2_d[i]   = in2_res[DATA_W-1:0];
                st_d[i]   = (in1_res[DATA_W] || in2_res[DATA_W]) ? StWait : StReady;
            end
            if (flush) begin
                st_d[i] = StFree;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                st_q[i]   <= StFree;
                rob_q[i]  <= '0;
                opg_q[i]  <= '0;
                ref1_q[i] <= 1'b0;
                ref2_q[i] <= 1'b0;
                d1_q[i]   <= '0;
                d2_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                st_q[i]   <= st_d[i];
                rob_q[i]  <= rob_d[i];
                opg_q[i]  <= opg_d[i];
                ref1_q[i] <= ref1_d[i];
                ref2_q[i] <= ref2_d[i];
                d1_q[i]   <= d1_d[i];
                d2_q[i]   <= d2_d[i];
            end
        end
    end

    always_comb begin
        rob_addr_out       = '0;
        opgen_out          = '0;
        operand_data_1_out = '0;
        operand_data_2_out = '0;
        count              = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (iss_oh[i]) begin
                rob_addr_out       = rob_q[i];
                opgen_out          = opg_q[i];
                operand_data_1_out = d1_q[i];
                operand_data_2_out = d2_q[i];
            end
            count = count + CntW'(st_q[i] != StFree);
        end
    end

endmodule

// File: tb/tb_rs_int_station.sv
// Randomized bench for rs_int_station against a behavioural entry-table model, plus
// directed scenarios for bypass, channel priority, full-station, flush and reset.
module tb_rs_int_station;

    localparam int DEPTH = 4;
    localparam int CH    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        write_en;
    logic        write_ready;
    logic [3:0]  rob_addr_in;
    logic [5:0]  opgen_in;
    logic        is_ref_1;
    logic        is_ref_2;
    logic [31:0] data_1;
    logic [31:0] data_2;
    logic [1:0]  bus_en;
    logic [7:0]  bus_ref_id;
    logic [63:0] bus_data;
    logic        issue_valid;
    logic        issue_ready;
    logic [3:0]  rob_addr_out;
    logic [5:0]  opgen_out;
    logic [31:0] data_1_out;
    logic [31:0] data_2_out;
    logic [2:0]  count;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: 0 = free, 1 = waiting on a tag, 2 = ready.
    int          m_st [DEPTH];
    logic [3:0]  m_rob[DEPTH];
    logic [5:0]  m_op [DEPTH];
    bit          m_r1 [DEPTH];
    bit          m_r2 [DEPTH];
    logic [31:0] m_d1 [DEPTH];
    logic [31:0] m_d2 [DEPTH];

    rs_int_station dut (
        .clk                (clk),
        .rst                (rst),
        .flush              (flush),
        .write_en           (write_en),
        .write_ready        (write_ready),
        .rob_addr_in        (rob_addr_in),
        .opgen_in           (opgen_in),
        .operand_is_ref_1_in(is_ref_1),
        .operand_is_ref_2_in(is_ref_2),
        .operand_data_1_in  (data_1),
        .operand_data_2_in  (data_2),
        .bus_en             (bus_en),
        .bus_ref_id_in      (bus_ref_id),
        .bus_data_in        (bus_data),
        .issue_valid        (issue_valid),
        .issue_ready        (issue_ready),
        .rob_addr_out       (rob_addr_out),
        .opgen_out          (opgen_out),
        .operand_data_1_out (data_1_out),
        .operand_data_2_out (data_2_out),
        .count              (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic bit cdb_hit(input logic [3:0] tag, output logic [31:0] val);
        for (int c = 0; c < CH; c++) begin
            if (bus_en[c] && bus_ref_id[c*4 +: 4] == tag) begin
                val = bus_data[c*32 +: 32];
                return 1'b1;
            end
        end
        val = '0;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_st[i] = 0; m_rob[i] = '0; m_op[i] = '0;
            m_r1[i] = 0; m_r2[i] = 0; m_d1[i] = '0; m_d2[i] = '0;
        end
    endtask

    // Apply the rules for one clock edge using the currently driven inputs.
    task automatic model_step();
        int wi = -1;
        int ii = -1;
        logic [31:0] v;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) m_st[i] = 0;
            return;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (wi < 0 && m_st[i] == 0) wi = i;
            if (ii < 0 && m_st[i] == 2) ii = i;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (m_st[i] == 1) begin
                if (m_r1[i] && cdb_hit(m_d1[i][3:0], v)) begin m_r1[i] = 0; m_d1[i] = v; end
                if (m_r2[i] && cdb_hit(m_d2[i][3:0], v)) begin m_r2[i] = 0; m_d2[i] = v; end
                if (!m_r1[i] && !m_r2[i]) m_st[i] = 2;
            end
        end
        if (ii >= 0 && issue_ready) m_st[ii] = 0;
        if (write_en && wi >= 0) begin
            m_rob[wi] = rob_addr_in;
            m_op[wi]  = opgen_in;
            m_r1[wi]  = is_ref_1;
            m_d1[wi]  = data_1;
            m_r2[wi]  = is_ref_2;
            m_d2[wi]  = data_2;
            if (m_r1[wi] && cdb_hit(data_1[3:0], v)) begin m_r1[wi] = 0; m_d1[wi] = v; end
            if (m_r2[wi] && cdb_hit(data_2[3:0], v)) begin m_r2[wi] = 0; m_d2[wi] = v; end
            m_st[wi] = (m_r1[wi] || m_r2[wi]) ? 1 : 2;
        end
    endtask

    task automatic compare_all();
        int ii = -1;
        int live = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ii < 0 && m_st[i] == 2) ii = i;
            if (m_st[i] != 0) live++;
        end
        check("issue_valid", issue_valid, ii >= 0);
        check("write_ready", write_ready, live < DEPTH);
        check("count", count, live);
        check("rob_addr_out", rob_addr_out, ii >= 0 ? m_rob[ii] : 4'h0);
        check("opgen_out", opgen_out, ii >= 0 ? m_op[ii] : 6'h0);
        check("data_1_out", data_1_out, ii >= 0 ? m_d1[ii] : 32'h0);
        check("data_2_out", data_2_out, ii >= 0 ? m_d2[ii] : 32'h0);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        flush = 0; write_en = 0; issue_ready = 0;
        rob_addr_in = '0; opgen_in = '0; is_ref_1 = 0; is_ref_2 = 0;
        data_1 = '0; data_2 = '0; bus_en = '0; bus_ref_id = '0; bus_data = '0;
    endtask

    task automatic set_write(input logic [3:0] rob, input logic [5:0] op, input logic r1,
                             input logic [31:0] d1, input logic r2, input logic [31:0] d2);
        write_en = 1; rob_addr_in = rob; opgen_in = op;
        is_ref_1 = r1; data_1 = d1; is_ref_2 = r2; data_2 = d2;
    endtask

    task automatic set_bus(input int ch, input logic [3:0] tag, input logic [31:0] d);
        bus_en[ch] = 1'b1;
        bus_ref_id[ch*4 +: 4] = tag;
        bus_data[ch*32 +: 32] = d;
    endtask

    initial begin
        rst = 0;
        idle();
        model_reset();
        #2;
        compare_all();
        @(negedge clk);
        rst = 1;

        // Both operands ready at write; issues next cycle.
        set_write(4'd3, 6'h0A, 0, 32'h11, 0, 32'h22); tick(); idle();
        check("d035_valid", issue_valid, 1'b1);
        check("d035_rob", rob_addr_out, 4'd3);
        check("d035_d1", data_1_out, 32'h11);
        check("d035_d2", data_2_out, 32'h22);
        issue_ready = 1; tick(); idle();
        check("d035_count", count, 3'd0);

        // Wakeup from channel 1.
        set_write(4'd1, 6'h02, 1, 32'h5, 0, 32'h7); tick(); idle();
        check("d036_wait", issue_valid, 1'b0);
        set_bus(1, 4'd5, 32'hABCD); tick(); idle();
        check("d036_valid", issue_valid, 1'b1);
        check("d036_d1", data_1_out, 32'hABCD);
        issue_ready = 1; tick(); idle();

        // Two channels match: channel 0 wins.
        set_write(4'd2, 6'h00, 1, 32'hF0F0_0002, 0, 32'h0); tick(); idle();
        set_bus(0, 4'd2, 32'h1); set_bus(1, 4'd2, 32'h2); tick(); idle();
        check("d038_d1", data_1_out, 32'h1);
        issue_ready = 1; tick(); idle();

        // Write-cycle bypass.
        set_write(4'd4, 6'h00, 1, 32'h7, 0, 32'h9); set_bus(0, 4'd7, 32'h55); tick(); idle();
        check("d039_valid", issue_valid, 1'b1);
        check("d039_d1", data_1_out, 32'h55);
        issue_ready = 1; tick(); idle();

        // Full station: write rejected even while an issue frees an entry.
        set_write(4'd8, 6'h01, 0, 32'hA, 0, 32'hB); tick(); idle();
        for (int k = 0; k < 3; k++) begin
            set_write(4'(9 + k), 6'h01, 1, 32'hE, 0, 32'h0); tick(); idle();
        end
        check("d037_ready", write_ready, 1'b0);
        check("d037_full", count, 3'd4);
        set_write(4'd15, 6'h01, 0, 32'h1, 0, 32'h1); issue_ready = 1; tick(); idle();
        check("d037_count", count, 3'd3);

        // Flush beats a simultaneous write.
        flush = 1; set_write(4'd6, 6'h01, 0, 32'h1, 0, 32'h1); tick(); idle();
        check("d040_count", count, 3'd0);
        check("d040_valid", issue_valid, 1'b0);

        for (int cyc = 0; cyc < 600; cyc++) begin
            idle();
            if ($urandom_range(0, 99) < 60) begin
                set_write(4'($urandom), 6'($urandom), 1'($urandom), $urandom,
                          1'($urandom), $urandom);
                if (is_ref_1) data_1[3:0] = 4'($urandom_range(0, 7));
                if (is_ref_2) data_2[3:0] = 4'($urandom_range(0, 7));
            end
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 99) < 40) set_bus(c, 4'($urandom_range(0, 7)), $urandom);
            end
            issue_ready = ($urandom_range(0, 99) < 55);
            flush = ($urandom_range(0, 99) < 2);
            if (cyc == 300) begin
                // Asynchronous reset mid-traffic, away from any clock edge.
                #2;
                rst = 0;
                #1;
                model_reset();
                compare_all();
                @(negedge clk);
                rst = 1;
                idle();
                set_write(4'd12, 6'h3F, 0, 32'h1234, 0, 32'h5678);
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
